// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared constants and the FSM state type for the sequential
// shift-and-add multiplier (mul_seq) and its handshake interface.
//   MUL_W      operand width
//   MUL_CNT_W  width of the RUN-pass counter
//   state_t    controller states
package mul_seq_pkg;

  localparam int MUL_W     = 8;
  localparam int MUL_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    CORR_A = 3'd2,
    CORR_B = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage : mul_seq_pkg

// File: rtl/mul_seq_if.sv
// mul_seq_if: request/response bundle of the sequential multiplier.
//   start   request a multiply (sampled only while idle)
//   a, b    multiplicand / multiplier
//   sgn     two's-complement operand mode (used only with MUL_SIGNED_EN)
//   busy    high whenever the multiplier is not idle
//   done    one-cycle pulse, product valid
//   product 2*MUL_W-bit result, held until the next accepted request
// The requester uses modport master, the multiplier uses modport slave.
interface mul_seq_if
  import mul_seq_pkg::*;
();

  logic               start;
  logic [MUL_W-1:0]   a;
  logic [MUL_W-1:0]   b;
  logic               sgn;
  logic               busy;
  logic               done;
  logic [2*MUL_W-1:0] product;

  modport master (
    output start, a, b, sgn,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b, sgn,
    output busy, done, product
  );

endinterface : mul_seq_if

// File: rtl/mul_seq_cla.sv
// CLAadder: 8-bit carry-lookahead adder, purely combinational.
//   a_i, b_i  addends
//   cin_i     carry in
//   sum_o     a_i + b_i + cin_i modulo 2^8
//   cout_o    carry out of bit 7
module CLAadder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] gen_w;
  logic [7:0] prop_w;
  logic [8:0] carry_w;

  // Carry into bit idx+1 written as a function of generate/propagate and
  // cin only (never of another carry wire), so each carry flattens to an
  // independent lookahead term.
  function automatic logic cla_carry(input int unsigned idx,
                                     input logic [7:0] gv,
                                     input logic [7:0] pv,
                                     input logic       cv);
    logic c;
    c = cv;
    for (int j = 0; j < 8; j++) begin
      if (j <= int'(idx)) c = gv[j] | (pv[j] & c);
    end
    return c;
  endfunction

  assign carry_w[0] = cin_i;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign gen_w[gi]       = a_i[gi] & b_i[gi];
      assign prop_w[gi]      = a_i[gi] ^ b_i[gi];
      assign carry_w[gi + 1] = cla_carry(gi, gen_w, prop_w, cin_i);
      assign sum_o[gi]       = prop_w[gi] ^ carry_w[gi];
    end
  endgenerate

  assign cout_o = carry_w[8];

endmodule : CLAadder

// File: rtl/mul_seq.sv
// mul_seq: sequential 8x8 shift-and-add multiplier, one adder pass per
// multiplier bit, using a single CLAadder whose operands are muxed by state.
//   clk    clock, all state updates on its rising edge
//   rst_n  synchronous active-low reset
//   bus    mul_seq_if.slave (start, a, b, sgn in; busy, done, product out)
// Build option: define MUL_SIGNED_EN to add two's-complement support
// (two correction passes CORR_A/CORR_B when sgn is captured high).
// Latency: 8 RUN cycles + DONE (unsigned), plus CORR_A/CORR_B (signed).
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [MUL_W-1:0]     a_q;
  logic [MUL_W-1:0]     b_q;
  logic [MUL_W-1:0]     acc_hi_q;
  logic [MUL_W-1:0]     acc_lo_q;
  logic [MUL_CNT_W-1:0] cnt_q;
`ifdef MUL_SIGNED_EN
  logic                 sgn_q;
`endif

  logic [MUL_W-1:0]     add_a_d;
  logic [MUL_W-1:0]     add_b_d;
  logic                 add_cin_d;
  logic [MUL_W-1:0]     add_sum;
  logic                 add_cout;

  // Adder operand mux. RUN adds the multiplicand when the current multiplier
  // bit (acc_lo[0]) is set. The signed passes subtract the other operand
  // from the high half (~x + 1), which turns the unsigned product into the
  // two's-complement one modulo 2^16.
  always_comb begin
    add_a_d   = acc_hi_q;
    add_b_d   = '0;
    add_cin_d = 1'b0;
    case (state_q)
      RUN: add_b_d = a_q & {MUL_W{acc_lo_q[0]}};
`ifdef MUL_SIGNED_EN
      CORR_A: begin
        add_b_d   = ~b_q;
        add_cin_d = 1'b1;
      end
      CORR_B: begin
        add_b_d   = ~a_q;
        add_cin_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  CLAadder u_add (
    .a_i    (add_a_d),
    .b_i    (add_b_d),
    .cin_i  (add_cin_d),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
`ifdef MUL_SIGNED_EN
      sgn_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
`ifdef MUL_SIGNED_EN
            sgn_q    <= bus.sgn;
`endif
            acc_hi_q <= '0;
            acc_lo_q <= bus.b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Shift right while the adder result enters at the top: the
          // multiplier bits drain out of acc_lo as product bits fill it.
          {acc_hi_q, acc_lo_q} <= {add_cout, add_sum, acc_lo_q[MUL_W-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
`ifdef MUL_SIGNED_EN
            if (sgn_q) begin
              state_q <= CORR_A;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        CORR_A: begin
          if (a_q[MUL_W-1]) acc_hi_q <= add_sum;
          state_q <= CORR_B;
        end
        CORR_B: begin
          if (b_q[MUL_W-1]) acc_hi_q <= add_sum;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = {acc_hi_q, acc_lo_q};

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed self-checking bench for mul_seq.
// Signed vectors are exercised only when MUL_SIGNED_EN is defined; in the
// default build a sgn=1 request must still give the unsigned product.
module tb_mul_seq;

  localparam int LAT_U = 9;
`ifdef MUL_SIGNED_EN
  localparam int LAT_S = 11;
`else
  localparam int LAT_S = 9;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mul_seq_if bus ();

  mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request: start pulsed for the accepting edge, then operands are
  // scrambled to prove they were captured. Latency counts edges from the
  // accepting edge (inclusive) to the cycle where done is seen.
  task automatic do_mul(input string tag, input logic [7:0] ia,
                        input logic [7:0] ib, input logic isgn,
                        input logic [15:0] exp_p, input int exp_lat);
    int edges;
    int busy_cyc;
    bit seen;
    @(negedge clk);
    check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    bus.a = ia; bus.b = ib; bus.sgn = isgn; bus.start = 1'b1;
    @(posedge clk);
    edges = 1;
    busy_cyc = 0;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~ia; bus.b = ib ^ 8'h5A; bus.sgn = ~isgn;
    while (edges < 40) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, edges, exp_lat);
    check({tag, "_product"}, {16'd0, bus.product}, {16'd0, exp_p});
    check({tag, "_busy_cycles"}, busy_cyc, exp_lat);
    @(negedge clk);
    check({tag, "_after_done_busy"}, {30'd0, bus.done, bus.busy}, 32'd0);
    check({tag, "_hold"}, {16'd0, bus.product}, {16'd0, exp_p});
    $display("op %s: a=0x%02h b=0x%02h sgn=%0d -> product=0x%04h lat=%0d",
             tag, ia, ib, isgn, bus.product, edges);
  endtask

  initial begin
    int edges;
    int dones;
    int d1_edge;
    int d2_edge;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.sgn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_product", {16'd0, bus.product}, 32'd0);
    $display("reset: busy=%0d done=%0d product=0x%04h", bus.busy, bus.done,
             bus.product);
    rst_n = 1'b1;

    do_mul("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, LAT_U);
    do_mul("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, LAT_U);
    do_mul("u0x200", 8'd0, 8'd200, 1'b0, 16'h0000, LAT_U);
    do_mul("u1x255", 8'd1, 8'hFF, 1'b0, 16'h00FF, LAT_U);
    do_mul("u128x2", 8'h80, 8'h02, 1'b0, 16'h0100, LAT_U);
`ifdef MUL_SIGNED_EN
    do_mul("s-1x-1", 8'hFF, 8'hFF, 1'b1, 16'h0001, LAT_S);
    do_mul("s-128x127", 8'h80, 8'h7F, 1'b1, 16'hC080, LAT_S);
    do_mul("s5x-3", 8'h05, 8'hFD, 1'b1, 16'hFFF1, LAT_S);
`else
    do_mul("sgn_ignored", 8'hFF, 8'hFF, 1'b1, 16'hFE01, LAT_S);
`endif

    // start held high: ops accepted at edges 1 and 11, operands changed
    // during the first RUN are picked up only by the second op.
    @(negedge clk);
    bus.a = 8'd13; bus.b = 8'd11; bus.sgn = 1'b0; bus.start = 1'b1;
    edges = 0; dones = 0; d1_edge = -1; d2_edge = -1;
    for (int c = 0; c < 26; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        bus.a = 8'h55; bus.b = 8'h66;
      end
      if (edges == 10) check("hold_idle_busy", {31'd0, bus.busy}, 32'd0);
      if (edges == 11) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          d1_edge = edges;
          check("hold_prod1", {16'd0, bus.product}, 32'h0000_008F);
        end else begin
          d2_edge = edges;
          check("hold_prod2", {16'd0, bus.product}, 32'h0000_21DE);
        end
      end
    end
    check("hold_done_count", dones, 2);
    check("hold_done1_edge", d1_edge, 9);
    check("hold_done2_edge", d2_edge, 19);
    $display("op hold_start: dones=%0d at edges %0d,%0d", dones, d1_edge,
             d2_edge);

    // Reset in the middle of RUN (cnt=4) aborts with no done pulse.
    @(negedge clk);
    bus.a = 8'd13; bus.b = 8'd11; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_product", {16'd0, bus.product}, 32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    $display("op abort: busy=%0d product=0x%04h dones_after=%0d", bus.busy,
             bus.product, dones);

    // Reset coincident with start wins.
    @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_vs_start_busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0; rst_n = 1'b1;
    $display("op rst_vs_start: busy=%0d", bus.busy);

    do_mul("post_reset13x11", 8'd13, 8'd11, 1'b0, 16'h008F, LAT_U);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mul_seq
